// File: rtl/tm1638_pkg.sv
// Shared command bytes, phase/state encodings and small helpers for the
// TM1638 frame sequencer.
package tm1638_pkg;

  localparam logic [7:0] TM_CMD_DATA_WR = 8'h40;
  localparam logic [7:0] TM_CMD_DATA_RD = 8'h42;
  localparam logic [7:0] TM_CMD_ADDR    = 8'hC0;
  localparam logic [7:0] TM_CMD_CTRL    = 8'h80;

  localparam int TMR_W    = 8;
  localparam int WDOG_CYC = 4;

  typedef enum logic [1:0] {
    PH_DATA,
    PH_ADDR,
    PH_CTRL,
    PH_KEYS
  } phase_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_STB_LO,
    S_ISSUE,
    S_ACK,
    S_XFER,
    S_NEXT,
    S_RD_WAIT,
    S_STB_HI,
    S_FIN
  } state_e;

  // Index of the final byte inside one STB window (command byte is index 0).
  function automatic logic [4:0] last_idx(input phase_e ph);
    case (ph)
      PH_ADDR: return 5'd16;
      PH_KEYS: return 5'd4;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [7:0] ctrl_byte(input logic on, input logic [2:0] br);
    return TM_CMD_CTRL | {4'b0000, on, br};
  endfunction

endpackage

// File: rtl/tm1638_frame_ctrl.sv
// One-shot TM1638 refresh sequencer: drives STB and feeds the byte engine
// through its latch/busy handshake for data, address+display, control and key scan.
module tm1638_frame_ctrl
  import tm1638_pkg::*;
#(
  parameter int STB_SETUP = 4,
  parameter int STB_GAP   = 8,
  parameter int READ_WAIT = 24,
  parameter bit KEY_SCAN  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] disp_data,
  input  logic [2:0]   brightness,
  input  logic         display_on,
  output logic         busy,
  output logic         done,
  output logic [31:0]  keys,
  output logic         keys_valid,
  output logic         stb_n,
  output logic         xfer_latch,
  output logic         xfer_rw,
  output logic [7:0]   xfer_wdata,
  input  logic [7:0]   xfer_rdata,
  input  logic         xfer_busy
);

  localparam logic [TMR_W-1:0] L_SETUP  = TMR_W'(STB_SETUP - 1);
  localparam logic [TMR_W-1:0] L_GAP    = TMR_W'(STB_GAP - 1);
  localparam logic [TMR_W-1:0] L_RDWAIT = TMR_W'(READ_WAIT - 1);
  localparam logic [TMR_W-1:0] L_WDOG   = TMR_W'(WDOG_CYC - 1);

  state_e           r_state;
  state_e           w_nxt;
  phase_e           r_phase;
  logic [4:0]       r_cnt;
  logic [TMR_W-1:0] r_tmr;
  logic             r_abort;
  logic [127:0]     r_disp;
  logic [2:0]       r_bright;
  logic             r_on;
  logic [31:0]      r_kacc;
  logic [31:0]      r_keys;

  logic             w_last_phase;
  logic             w_is_read;
  logic             w_xfer_act;
  logic [3:0]       w_didx;
  logic [1:0]       w_kidx;
  logic [7:0]       w_byte;

  assign w_last_phase = (r_phase == PH_KEYS) || ((r_phase == PH_CTRL) && !KEY_SCAN);
  assign w_is_read    = (r_phase == PH_KEYS) && (r_cnt != 5'd0);
  assign w_xfer_act   = (r_state == S_ISSUE) || (r_state == S_ACK) || (r_state == S_XFER);
  assign w_didx       = 4'(r_cnt - 5'd1);
  assign w_kidx       = 2'(r_cnt - 5'd1);

  always_comb begin
    w_byte = TM_CMD_DATA_WR;
    case (r_phase)
      PH_ADDR: w_byte = (r_cnt == 5'd0) ? TM_CMD_ADDR : r_disp[{w_didx, 3'b000} +: 8];
      PH_CTRL: w_byte = ctrl_byte(r_on, r_bright);
      PH_KEYS: w_byte = (r_cnt == 5'd0) ? TM_CMD_DATA_RD : 8'h00;
      default: w_byte = TM_CMD_DATA_WR;
    endcase
  end

  always_comb begin
    w_nxt      = r_state;
    xfer_latch = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_nxt = S_STB_LO;
      S_STB_LO:  if (r_tmr == L_SETUP) w_nxt = S_ISSUE;
      S_ISSUE: begin
        if (!xfer_busy) begin
          xfer_latch = 1'b1;
          w_nxt      = S_ACK;
        end
      end
      // Engine that never acknowledges closes the frame early.
      S_ACK: begin
        if (xfer_busy) w_nxt = S_XFER;
        else if (r_tmr == L_WDOG) w_nxt = S_STB_HI;
      end
      S_XFER:    if (!xfer_busy) w_nxt = S_NEXT;
      S_NEXT: begin
        if ((r_phase == PH_KEYS) && (r_cnt == 5'd0)) w_nxt = S_RD_WAIT;
        else if (r_cnt == last_idx(r_phase)) w_nxt = S_STB_HI;
        else w_nxt = S_ISSUE;
      end
      S_RD_WAIT: if (r_tmr == L_RDWAIT) w_nxt = S_ISSUE;
      S_STB_HI: begin
        if (r_tmr == L_GAP) w_nxt = (r_abort || w_last_phase) ? S_FIN : S_STB_LO;
      end
      S_FIN:     w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_phase <= PH_DATA;
      r_cnt   <= 5'd0;
      r_tmr   <= '0;
      r_abort <= 1'b0;
      r_keys  <= 32'h0;
    end else begin
      r_state <= w_nxt;
      r_tmr   <= (w_nxt != r_state) ? '0 : r_tmr + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_phase <= PH_DATA;
            r_cnt   <= 5'd0;
            r_abort <= 1'b0;
          end
        end
        S_ACK:  if (w_nxt == S_STB_HI) r_abort <= 1'b1;
        S_NEXT: if (w_nxt != S_STB_HI) r_cnt <= r_cnt + 5'd1;
        S_STB_HI: begin
          if (w_nxt == S_STB_LO) begin
            r_cnt <= 5'd0;
            case (r_phase)
              PH_DATA: r_phase <= PH_ADDR;
              PH_ADDR: r_phase <= PH_CTRL;
              default: r_phase <= PH_KEYS;
            endcase
          end
          // Publish keys only after a complete scan.
          if ((w_nxt == S_FIN) && (r_phase == PH_KEYS) && !r_abort) r_keys <= r_kacc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && start) begin
      r_disp   <= disp_data;
      r_bright <= brightness;
      r_on     <= display_on;
    end
    if ((r_state == S_XFER) && !xfer_busy && w_is_read)
      r_kacc[{w_kidx, 3'b000} +: 8] <= xfer_rdata;
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_FIN);
  assign keys_valid = done && (r_phase == PH_KEYS) && !r_abort;
  assign keys       = r_keys;
  assign stb_n      = (r_state == S_IDLE) || (r_state == S_STB_HI) || (r_state == S_FIN);
  assign xfer_rw    = !(w_xfer_act && w_is_read);
  assign xfer_wdata = w_xfer_act ? w_byte : 8'h00;

endmodule

// File: tb/tb_tm1638_frame_ctrl.sv
// Directed bench for tm1638_frame_ctrl: a byte-engine model (busy one cycle
// after latch, 36 cycles long) logs every latched byte for later comparison.
module tb_tm1638_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, start = 1'b0, start0 = 1'b0, sel = 1'b1, bfm_mute = 1'b0;
  logic [127:0] disp_data = '0;
  logic [2:0]   brightness = 3'd0;
  logic         display_on = 1'b0;
  logic [7:0]   xfer_rdata = 8'h00;
  logic         xfer_busy;

  logic         busy, done, keys_valid, stb_n, xfer_latch, xfer_rw;
  logic [31:0]  keys;
  logic [7:0]   xfer_wdata;
  logic         busy0, done0, keys_valid0, stb_n0, xfer_latch0, xfer_rw0;
  logic [31:0]  keys0;
  logic [7:0]   xfer_wdata0;

  tm1638_frame_ctrl #(.KEY_SCAN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .disp_data(disp_data),
    .brightness(brightness), .display_on(display_on), .busy(busy), .done(done),
    .keys(keys), .keys_valid(keys_valid), .stb_n(stb_n), .xfer_latch(xfer_latch),
    .xfer_rw(xfer_rw), .xfer_wdata(xfer_wdata), .xfer_rdata(xfer_rdata),
    .xfer_busy(xfer_busy)
  );

  tm1638_frame_ctrl #(.KEY_SCAN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .disp_data(disp_data),
    .brightness(brightness), .display_on(display_on), .busy(busy0), .done(done0),
    .keys(keys0), .keys_valid(keys_valid0), .stb_n(stb_n0), .xfer_latch(xfer_latch0),
    .xfer_rw(xfer_rw0), .xfer_wdata(xfer_wdata0), .xfer_rdata(xfer_rdata),
    .xfer_busy(xfer_busy)
  );

  // One engine model shared by both instances; sel picks the active one.
  logic       m_latch, m_rw, m_stb, m_done, m_kv;
  logic [7:0] m_wd;
  assign m_latch = sel ? xfer_latch : xfer_latch0;
  assign m_rw    = sel ? xfer_rw    : xfer_rw0;
  assign m_stb   = sel ? stb_n      : stb_n0;
  assign m_done  = sel ? done       : done0;
  assign m_kv    = sel ? keys_valid : keys_valid0;
  assign m_wd    = sel ? xfer_wdata : xfer_wdata0;

  int vecs = 0, fails = 0;
  int cyc = 0, n = 0, rd_n = 0, win_n = 0, done_n = 0, kv_n = 0, bcnt = 0;
  logic [7:0] log_d   [512];
  logic       log_rw  [512];
  logic       log_stb [512];
  int         log_cyc [512];
  logic [7:0] rtab [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic       prev_stb = 1'b1;

  assign xfer_busy = (bcnt != 0);

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_stb <= m_stb;
    if (prev_stb === 1'b1 && m_stb === 1'b0) win_n <= win_n + 1;
    if (m_done === 1'b1) done_n <= done_n + 1;
    if (m_kv === 1'b1 && m_done === 1'b1) kv_n <= kv_n + 1;
    if (m_latch === 1'b1) begin
      log_d[n]   <= m_wd;
      log_rw[n]  <= m_rw;
      log_stb[n] <= m_stb;
      log_cyc[n] <= cyc;
      n          <= n + 1;
      if (m_rw === 1'b0) begin
        xfer_rdata <= rtab[rd_n % 4];
        rd_n       <= rd_n + 1;
      end
      if (!bfm_mute) bcnt <= 36;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_n > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Expected byte k of a frame: 40 | C0 d0..d15 | ctrl | 42 | reads.
  function automatic logic [7:0] exp_byte(input int k, input logic [127:0] dd,
                                          input logic [2:0] br, input logic on);
    if (k == 0) return 8'h40;
    if (k == 1) return 8'hC0;
    if (k <= 17) return dd[8*(k-2) +: 8];
    if (k == 18) return 8'h80 | {4'b0000, on, br};
    if (k == 19) return 8'h42;
    return 8'h00;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vecs++; if (stb_n !== 1'b1) begin fails++; $display("FAIL rst_stb_n: got %b want 1", stb_n); end
    vecs++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    vecs++; if (xfer_latch !== 1'b0) begin fails++; $display("FAIL rst_latch: got %b want 0", xfer_latch); end
    vecs++; if (keys !== 32'h0) begin fails++; $display("FAIL rst_keys: got %h want 00000000", keys); end
    vecs++; if ({done, keys_valid} !== 2'b00) begin fails++; $display("FAIL rst_done_kv: got %b want 00", {done, keys_valid}); end
    vecs++; if ({xfer_rw, xfer_wdata} !== 9'h100) begin fails++; $display("FAIL rst_rw_wdata: got %h want 100", {xfer_rw, xfer_wdata}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_no_scan();
    int b, w, d, k;
    bit ok;
    logic [7:0] e;
    sel = 1'b0;
    for (int i = 0; i < 16; i++) disp_data[8*i +: 8] = 8'(i + 1);
    brightness = 3'd5;
    display_on = 1'b1;
    b = n; w = win_n; d = done_n; k = kv_n;
    start0 = 1'b1; tick(); start0 = 1'b0;
    vecs++; if (busy0 !== 1'b1) begin fails++; $display("FAIL t2_busy: got %b want 1", busy0); end
    wait_done(d, 3000, ok);
    vecs++; if (!ok) begin fails++; $display("FAIL t2_done_timeout: got none want done"); end
    repeat (20) tick();
    vecs++; if (n - b !== 19) begin fails++; $display("FAIL t2_nbytes: got %0d want 19", n - b); end
    for (int i = 0; i < 19; i++) begin
      e = exp_byte(i, disp_data, 3'd5, 1'b1);
      vecs++;
      if (log_rw[b+i] !== 1'b1 || log_d[b+i] !== e || log_stb[b+i] !== 1'b0) begin
        fails++;
        $display("FAIL t2_byte%0d: got rw=%b d=%h stb=%b want rw=1 d=%h stb=0",
                 i, log_rw[b+i], log_d[b+i], log_stb[b+i], e);
      end
    end
    vecs++; if (win_n - w !== 3) begin fails++; $display("FAIL t2_windows: got %0d want 3", win_n - w); end
    vecs++; if (done_n - d !== 1) begin fails++; $display("FAIL t2_done_count: got %0d want 1", done_n - d); end
    vecs++; if (kv_n - k !== 0) begin fails++; $display("FAIL t2_keys_valid: got %0d want 0", kv_n - k); end
    vecs++; if ({stb_n0, busy0} !== 2'b10) begin fails++; $display("FAIL t2_idle: got %b want 10", {stb_n0, busy0}); end
    sel = 1'b1;
  endtask

  task automatic test_key_scan();
    int b, w, d, k;
    bit ok;
    logic [7:0] e;
    logic erw;
    sel = 1'b1;
    for (int i = 0; i < 16; i++) disp_data[8*i +: 8] = 8'hA0 + 8'(i);
    brightness = 3'd2;
    display_on = 1'b0;
    b = n; w = win_n; d = done_n; k = kv_n;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(d, 3000, ok);
    vecs++; if (!ok) begin fails++; $display("FAIL t3_done_timeout: got none want done"); end
    repeat (20) tick();
    vecs++; if (n - b !== 24) begin fails++; $display("FAIL t3_nbytes: got %0d want 24", n - b); end
    for (int i = 0; i < 24; i++) begin
      e = exp_byte(i, disp_data, 3'd2, 1'b0);
      erw = (i < 20);
      vecs++;
      if (log_rw[b+i] !== erw || (erw && log_d[b+i] !== e) || log_stb[b+i] !== 1'b0) begin
        fails++;
        $display("FAIL t3_byte%0d: got rw=%b d=%h stb=%b want rw=%b d=%h stb=0",
                 i, log_rw[b+i], log_d[b+i], log_stb[b+i], erw, e);
      end
    end
    vecs++; if (keys !== 32'h44332211) begin fails++; $display("FAIL t3_keys: got %h want 44332211", keys); end
    vecs++; if (kv_n - k !== 1) begin fails++; $display("FAIL t3_keys_valid: got %0d want 1", kv_n - k); end
    vecs++; if (win_n - w !== 4) begin fails++; $display("FAIL t3_windows: got %0d want 4", win_n - w); end
    vecs++;
    if (log_cyc[b+20] - log_cyc[b+19] < 61) begin
      fails++;
      $display("FAIL t3_read_wait: got %0d want >=61", log_cyc[b+20] - log_cyc[b+19]);
    end
  endtask

  task automatic test_snapshot();
    int b, d;
    bit ok;
    logic [127:0] sdd;
    logic [7:0] e;
    logic erw;
    for (int i = 0; i < 16; i++) disp_data[8*i +: 8] = 8'(i * 3 + 7);
    brightness = 3'd7;
    display_on = 1'b1;
    sdd = disp_data;
    b = n; d = done_n;
    start = 1'b1; tick(); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (n >= b + 6) begin ok = 1'b1; break; end
    end
    vecs++; if (!ok) begin fails++; $display("FAIL t4_mid_timeout: got %0d bytes want 6", n - b); end
    disp_data  = ~sdd;
    brightness = 3'd0;
    display_on = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    vecs++; if (busy !== 1'b1) begin fails++; $display("FAIL t4_busy: got %b want 1", busy); end
    wait_done(d, 3000, ok);
    vecs++; if (!ok) begin fails++; $display("FAIL t4_done_timeout: got none want done"); end
    repeat (60) tick();
    vecs++; if (n - b !== 24) begin fails++; $display("FAIL t4_nbytes: got %0d want 24", n - b); end
    for (int i = 0; i < 24; i++) begin
      e = exp_byte(i, sdd, 3'd7, 1'b1);
      erw = (i < 20);
      vecs++;
      if (log_rw[b+i] !== erw || (erw && log_d[b+i] !== e)) begin
        fails++;
        $display("FAIL t4_byte%0d: got rw=%b d=%h want rw=%b d=%h", i, log_rw[b+i], log_d[b+i], erw, e);
      end
    end
    vecs++; if (done_n - d !== 1) begin fails++; $display("FAIL t4_done_count: got %0d want 1", done_n - d); end
    vecs++; if (busy !== 1'b0) begin fails++; $display("FAIL t4_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int b, d, k;
    bit ok;
    logic [7:0] e;
    logic erw;
    for (int i = 0; i < 16; i++) disp_data[8*i +: 8] = 8'h55 ^ 8'(i);
    brightness = 3'd3;
    display_on = 1'b1;
    b = n; d = done_n;
    start = 1'b1; tick(); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (n >= b + 10) begin ok = 1'b1; break; end
    end
    vecs++; if (!ok) begin fails++; $display("FAIL t5_mid_timeout: got %0d bytes want 10", n - b); end
    rst = 1'b1; tick();
    vecs++; if ({stb_n, busy} !== 2'b10) begin fails++; $display("FAIL t5_abort: got %b want 10", {stb_n, busy}); end
    rst = 1'b0;
    repeat (10) tick();
    vecs++; if (done_n !== d) begin fails++; $display("FAIL t5_no_done: got %0d want 0", done_n - d); end
    b = n; d = done_n; k = kv_n;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(d, 3000, ok);
    vecs++; if (!ok) begin fails++; $display("FAIL t5_done_timeout: got none want done"); end
    repeat (20) tick();
    vecs++; if (n - b !== 24) begin fails++; $display("FAIL t5_nbytes: got %0d want 24", n - b); end
    for (int i = 0; i < 24; i++) begin
      e = exp_byte(i, disp_data, 3'd3, 1'b1);
      erw = (i < 20);
      vecs++;
      if (log_rw[b+i] !== erw || (erw && log_d[b+i] !== e) || log_stb[b+i] !== 1'b0) begin
        fails++;
        $display("FAIL t5_byte%0d: got rw=%b d=%h stb=%b want rw=%b d=%h stb=0",
                 i, log_rw[b+i], log_d[b+i], log_stb[b+i], erw, e);
      end
    end
    vecs++; if (kv_n - k !== 1) begin fails++; $display("FAIL t5_keys_valid: got %0d want 1", kv_n - k); end
    vecs++; if (keys !== 32'h44332211) begin fails++; $display("FAIL t5_keys: got %h want 44332211", keys); end
  endtask

  task automatic test_watchdog();
    int b, d, k;
    bit ok;
    bfm_mute = 1'b1;
    b = n; d = done_n; k = kv_n;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(d, 300, ok);
    vecs++; if (!ok) begin fails++; $display("FAIL t6_done_timeout: got none want done"); end
    vecs++; if (stb_n !== 1'b1) begin fails++; $display("FAIL t6_stb_at_done: got %b want 1", stb_n); end
    tick();
    vecs++; if (n - b !== 1) begin fails++; $display("FAIL t6_nlatch: got %0d want 1", n - b); end
    vecs++; if (kv_n - k !== 0) begin fails++; $display("FAIL t6_keys_valid: got %0d want 0", kv_n - k); end
    vecs++; if ({stb_n, busy} !== 2'b10) begin fails++; $display("FAIL t6_idle: got %b want 10", {stb_n, busy}); end
    vecs++; if (keys !== 32'h44332211) begin fails++; $display("FAIL t6_keys_held: got %h want 44332211", keys); end
    bfm_mute = 1'b0;
  endtask

  initial begin
    test_reset();
    test_no_scan();
    test_key_scan();
    test_snapshot();
    test_reset_mid();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
